// File: rtl/reg_loader.sv
// ---------------------------------------------------------------------------
// reg_loader: streams source bytes into a protected register file range.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_loader #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] base_addr,
  input  logic [D-1:0] len,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         abort,
  output logic         write_en,
  output logic [D-1:0] w_addr,
  output logic [W-1:0] data_in,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [D:0]   DEPTH = (D+1)'(2**D);
  localparam logic [D-1:0] ONE   = D'(1);

  state_t         state_q, state_d;
  logic [D-1:0]   addr_cnt_q, addr_cnt_d;
  logic [D-1:0]   remaining_q, remaining_d;
  logic           write_en_q, write_en_d;
  logic [D-1:0]   w_addr_q, w_addr_d;
  logic [W-1:0]   data_in_q, data_in_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [D:0]     end_sum;

  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    remaining_d = remaining_q;
    write_en_d  = 1'b0;
    w_addr_d    = w_addr_q;
    data_in_d   = data_in_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    end_sum     = {1'b0, base_addr} + {1'b0, len};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else if ((base_addr == '0) || (end_sum > DEPTH)) begin
            // register 0 is write-protected and the range may not wrap
            err_d = 1'b1;
          end else begin
            state_d     = LOAD;
            addr_cnt_d  = base_addr;
            remaining_d = len;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          write_en_d  = 1'b1;
          w_addr_d    = addr_cnt_q;
          data_in_d   = in_data;
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // only step the pointer while beats remain, so it never wraps
            addr_cnt_d = addr_cnt_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_cnt_q  <= '0;
      remaining_q <= '0;
      write_en_q  <= 1'b0;
      w_addr_q    <= '0;
      data_in_q   <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      remaining_q <= remaining_d;
      write_en_q  <= write_en_d;
      w_addr_q    <= w_addr_d;
      data_in_q   <= data_in_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign write_en = write_en_q;
  assign w_addr   = w_addr_q;
  assign data_in  = data_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: doc/reg_loader.md
REG_LOADER -- requirements
Module: reg_loader

Interface
REQ-001 Parameter W, default 8, data path width (fixed at 8).
REQ-002 Parameter D, default 3, register pointer width; register file depth is 2**D.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle load request, sampled in IDLE only.
REQ-006 base_addr  input  D  first register to load.
REQ-007 len  input  D  number of registers to load.
REQ-008 in_valid  input  1  source byte valid.
REQ-009 in_data  input  W  source byte.
REQ-010 in_ready  output  1  loader accepts a byte this cycle.
REQ-011 abort  input  1  cancel an in-progress load.
REQ-012 write_en  output  1  register file write strobe.
REQ-013 w_addr  output  D  register file write address.
REQ-014 data_in  output  W  register file write data.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  one-cycle pulse on load completion.
REQ-017 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-018 The FSM SHALL have states IDLE and LOAD.
REQ-019 All outputs SHALL be registered; in_ready SHALL equal (state==LOAD).
REQ-020 Start check in IDLE: start=1 and len!=0 and base_addr!=0 and base_addr+len<=2**D (D+1-bit sum) -> LOAD next cycle; capture addr_cnt=base_addr and remaining=len; busy=1.
REQ-021 IDLE with start=1 and len==0 -> stay IDLE; done=1 next cycle; no write.
REQ-022 IDLE with start=1, len!=0, and base_addr==0 (register 0 is write-protected) or base_addr+len>2**D (wrap) -> stay IDLE; err=1 next cycle; no write.
REQ-023 start SHALL be ignored while in LOAD.
REQ-024 Beat acceptance: in LOAD, in_valid=1 and abort=0 -> in the next cycle write_en=1, w_addr=addr_cnt, data_in=in_data; addr_cnt increments and remaining decrements; latency 1 cycle.
REQ-025 In LOAD with in_valid=0, write_en SHALL be 0 next cycle; w_addr and data_in SHALL hold their last values.
REQ-026 Back-to-back valid beats SHALL produce one write per cycle with no bubbles.
REQ-027 On acceptance of the final beat (remaining==1): next cycle write_en=1 for that beat, done=1, busy=0, state=IDLE, in_ready=0.
REQ-028 A new start SHALL be accepted in the cycle done is asserted (IDLE entered).
REQ-029 abort=1 in LOAD -> IDLE next cycle; busy=0; done=0; any beat presented in the abort cycle SHALL be discarded (write_en=0 next cycle); writes already issued SHALL stand.
REQ-030 abort in IDLE SHALL have no effect.
REQ-031 The addr_cnt arithmetic is D bits and SHALL never wrap, guaranteed by REQ-022.
REQ-032 write_en, done and err SHALL never be high for more than one cycle per event; done and err SHALL never both be high.

Reset
REQ-033 reset=0 SHALL immediately force: state=IDLE, write_en=0, w_addr=0, data_in=0, in_ready=0, busy=0, done=0, err=0, addr_cnt=0, remaining=0.
REQ-034 Reset asserted mid-load SHALL abandon the load with no further writes; the first post-reset cycle is IDLE.
REQ-035 Reset release SHALL be treated as synchronous to clk; start in the first cycle after release SHALL be honoured.

Verification
REQ-036 start, base=1, len=7, bytes 0x11..0x77 streamed back to back -> writes r1..r7 = 0x11..0x77 on 7 consecutive cycles; done pulses with the r7 write; busy drops.
REQ-037 start, base=5, len=3, and in_valid toggling 1,0,1,0,1 -> exactly 3 writes (r5, r6, r7), each one cycle after its accepted beat; write_en=0 in gap cycles.
REQ-038 start, base=0, len=2 -> err=1 for one cycle, in_ready stays 0, no write_en; start, base=6, len=3 -> err=1; start, base=4, len=0 -> done=1, no err.
REQ-039 start, base=2, len=4; after 2 beats, abort together with a valid 0xAA beat -> r2 and r3 written only, 0xAA not written, busy=0, done never asserted.
REQ-040 start, base=3, len=3; after 1 beat, drive reset=0 asynchronously mid-cycle -> all outputs 0 immediately; after release, start base=1, len=1 with 0x5A -> r1=0x5A, done=1.
